seg7_reader: RTL and testbench

Decoding counterpart of the team's BCD-to-7-segment driver. Samples a time-multiplexed, active-low 7-segment bus (segment lines plus one-hot active-low digit selects) and reconstructs the digit value shown on each display position. Debounces every sample window, decodes segments back to BCD and stores one nibble per digit. Used as a loopback checker and observer of display outputs on the lab board.

---
 rtl/seg7_reader.sv | 144 ++++++++++++++
 tb/tb_seg7_reader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// Observes a multiplexed active-low 7-segment bus and rebuilds the BCD nibble shown per digit.
// Optional SEG7_READER_ERRCNT_EN adds a saturating error-capture counter output err_cnt.
module seg7_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          segments,
    input  logic [DIGITS-1:0]   digit_sel,
    input  logic                err_clr,
    output logic [4*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                upd,
    output logic [2:0]          upd_idx,
    output logic [3:0]          upd_val,
    output logic                err
`ifdef SEG7_READER_ERRCNT_EN
    ,
    output logic [7:0]          err_cnt
`endif
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [6:0]        seg_q, seg_p;
    logic [DIGITS-1:0] sel_q, sel_p;
    logic [3:0]        nlow;
    logic [2:0]        sel_idx;
    logic              sel_ok, changed, cap;
    logic [3:0]        cap_val;

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b000_0001: seg_decode = 4'd0;
            7'b100_1111: seg_decode = 4'd1;
            7'b001_0010: seg_decode = 4'd2;
            7'b000_0110: seg_decode = 4'd3;
            7'b100_1100: seg_decode = 4'd4;
            7'b010_0100: seg_decode = 4'd5;
            7'b010_0000: seg_decode = 4'd6;
            7'b000_1111: seg_decode = 4'd7;
            7'b000_0000: seg_decode = 4'd8;
            7'b000_1100: seg_decode = 4'd9;
            7'b111_1111: seg_decode = 4'hF;
            default:     seg_decode = 4'hE;
        endcase
    endfunction

    always_comb begin
        nlow    = '0;
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!sel_q[i]) begin
                nlow    = nlow + 4'd1;
                sel_idx = 3'(i);
            end
        end
        sel_ok  = (nlow == 4'd1);
        changed = (seg_q != seg_p) || (sel_q != sel_p);
        // Capture lands on the edge that would take the counter to STABLE_CYCLES.
        cap     = (state == SETTLE) && !changed && (cnt == CW'(STABLE_CYCLES - 1));
        cap_val = seg_decode(seg_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            seg_q       <= 7'h7F;
            seg_p       <= 7'h7F;
            sel_q       <= '1;
            sel_p       <= '1;
            digits      <= '1;
            digit_valid <= '0;
            upd         <= 1'b0;
            upd_idx     <= '0;
            upd_val     <= 4'hF;
            err         <= 1'b0;
`ifdef SEG7_READER_ERRCNT_EN
            err_cnt     <= '0;
`endif
        end else begin
            seg_q <= segments;
            sel_q <= digit_sel;
            seg_p <= seg_q;
            sel_p <= sel_q;
            upd   <= 1'b0;
            if (err_clr) err <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_ok) begin
                        state <= SETTLE;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                SETTLE, HOLD: begin
                    if (changed) begin
                        if (sel_ok) begin
                            state <= SETTLE;
                            cnt   <= CW'(1);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else if (cap) begin
                        state   <= HOLD;
                        cnt     <= CW'(STABLE_CYCLES);
                        upd     <= 1'b1;
                        upd_idx <= sel_idx;
                        upd_val <= cap_val;
                        for (int g = 0; g < DIGITS; g++) begin
                            if (sel_idx == 3'(g)) begin
                                digits[4*g +: 4] <= cap_val;
                                digit_valid[g]   <= (cap_val <= 4'd9);
                            end
                        end
                        // Set wins over a same-cycle err_clr.
                        if (cap_val == 4'hE) begin
                            err <= 1'b1;
`ifdef SEG7_READER_ERRCNT_EN
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
                        end
                    end else if (state == SETTLE) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Randomised + directed scoreboard bench for seg7_reader; reference model tracks run lengths of
// identical input samples and predicts each capture edge, value and stored digit image.
module tb_seg7_reader;
    localparam int D = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [6:0]     segments;
    logic [D-1:0]   digit_sel;
    logic           err_clr;
    logic [4*D-1:0] digits;
    logic [D-1:0]   digit_valid;
    logic           upd;
    logic [2:0]     upd_idx;
    logic [3:0]     upd_val;
    logic           err;
`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0]     err_cnt;
`endif

    seg7_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .segments(segments), .digit_sel(digit_sel), .err_clr(err_clr),
        .digits(digits), .digit_valid(digit_valid), .upd(upd), .upd_idx(upd_idx),
        .upd_val(upd_val), .err(err)
`ifdef SEG7_READER_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int             at;
        int             idx;
        logic [3:0]     val;
        logic [4*D-1:0] dig;
        logic [D-1:0]   dv;
    } exp_t;

    exp_t           q[$];
    int             tests = 0;
    int             fails = 0;
    int             ecount = 0;
    int             rl;
    logic [6:0]     lseg;
    logic [D-1:0]   lsel;
    logic [4*D-1:0] m_dig;
    logic [D-1:0]   m_dv;
    logic           m_err;
    int             m_cnt;
    logic [6:0]     pat [10] = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110, 7'b100_1100,
                                 7'b010_0100, 7'b010_0000, 7'b000_1111, 7'b000_0000, 7'b000_1100};

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        if (s == 7'h7F) return 4'hF;
        for (int k = 0; k < 10; k++) if (pat[k] == s) return 4'(k);
        return 4'hE;
    endfunction

    function automatic int low_pos(input logic [D-1:0] sel);
        for (int k = 0; k < D; k++) if (!sel[k]) return k;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Reference model: a capture is due one edge after a run of exactly S identical valid samples.
    always @(posedge clk) begin
        exp_t e;
        ecount++;
        if (rst) begin
            lseg = 7'h7F; lsel = '1; rl = 1;
            q.delete();
            m_dig = '1; m_dv = '0; m_err = 1'b0; m_cnt = 0;
        end else begin
            if (q.size() > 0 && q[0].at == ecount && q[0].val == 4'hE) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end else if (err_clr) begin
                m_err = 1'b0;
            end
            if (segments == lseg && digit_sel == lsel) rl++;
            else rl = 1;
            lseg = segments; lsel = digit_sel;
            if (rl == S && $countones(~digit_sel) == 1) begin
                e.at  = ecount + 1;
                e.idx = low_pos(digit_sel);
                e.val = ref_decode(segments);
                m_dig[4*e.idx +: 4] = e.val;
                m_dv[e.idx]         = (e.val <= 4'd9);
                e.dig = m_dig;
                e.dv  = m_dv;
                q.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queue, away from the active edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("rst_upd", upd, 0);
            chk("rst_digits", digits, {4*D{1'b1}});
            chk("rst_valid", digit_valid, 0);
            chk("rst_idx", upd_idx, 0);
            chk("rst_val", upd_val, 4'hF);
            chk("rst_err", err, 0);
        end else begin
            if (upd) begin
                if (q.size() == 0 || q[0].at != ecount) begin
                    chk("spurious_upd", upd, 0);
                end else begin
                    chk("upd_idx", upd_idx, q[0].idx);
                    chk("upd_val", upd_val, q[0].val);
                    chk("digits", digits, q[0].dig);
                    chk("digit_valid", digit_valid, q[0].dv);
`ifdef SEG7_READER_ERRCNT_EN
                    chk("err_cnt", err_cnt, m_cnt);
`endif
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && q[0].at <= ecount) begin
                chk("missing_upd", upd, 1);
                void'(q.pop_front());
            end
            chk("err", err, m_err);
        end
    end

    task automatic hold(input logic [6:0] seg, input logic [D-1:0] sel, input int n, input int clr_mask);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            segments  = seg;
            digit_sel = sel;
            err_clr   = clr_mask[k];
        end
    endtask

    initial begin
        rst = 1'b1; segments = 7'h7F; digit_sel = '1; err_clr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            segments = 7'($urandom); digit_sel = D'($urandom); err_clr = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; segments = 7'h7F; digit_sel = '1; err_clr = 1'b0;
        hold(7'h7F, '1, 3, 0);
        hold(7'b001_0010, 4'b1101, 6, 0);
        hold(7'b001_0010, 4'b1101, 3, 0);
        hold(7'b000_0110, 4'b1101, 6, 0);
        // Error pattern with err_clr on the capture edge, then err_clr alone on the next.
        hold(7'b111_1110, 4'b1110, 7, (1 << S) | (1 << (S + 1)));
        hold(7'b000_0001, 4'b1100, 10, 0);
        hold(7'h7F, 4'b0111, 6, 0);
        // Reset mid-window drops the pending capture.
        hold(7'b100_1111, 4'b1011, 3, 0);
        @(negedge clk); rst = 1'b1;
        hold(7'b100_1111, 4'b1011, 3, 0);
        @(negedge clk); rst = 1'b0;
        for (int r = 0; r < 300; r++) begin
            int kind, pos;
            logic [6:0] seg;
            logic [D-1:0] sel;
            kind = $urandom_range(0, 9);
            if (kind < 6) seg = pat[$urandom_range(0, 9)];
            else if (kind == 6) seg = 7'h7F;
            else seg = 7'($urandom);
            pos = $urandom_range(0, D - 1);
            sel = ($urandom_range(0, 5) == 0) ? D'($urandom) : ~(D'(1) << pos);
            hold(seg, sel, $urandom_range(1, 7), ($urandom_range(0, 5) == 0) ? int'($urandom) : 0);
        end
`ifdef SEG7_READER_ERRCNT_EN
        for (int r = 0; r < 300; r++) hold((r % 2) ? 7'b111_1101 : 7'b111_1110, 4'b1110, S, 0);
        hold(7'h7F, '1, S + 2, 0);
        chk("err_cnt_sat", err_cnt, 255);
`endif
        hold(7'h7F, '1, S + 3, 0);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
